// File: rtl/pwm_generator.sv
// pwm_generator
//   Shadow-registered PWM output stage. Top/compare updates from the
//   sequencer are captured into shadow registers and only become active
//   at a period boundary (count == active top) or while disabled, so the
//   duty cycle and period never change in the middle of a period.
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         run enable (level)
//   i_top            new period top; period length = top + 1 cycles
//   i_top_valid      single-cycle strobe qualifying i_top
//   i_compare        new compare; output high while count < compare
//   i_compare_valid  single-cycle strobe qualifying i_compare
//   o_pwm            registered PWM output (lags o_count by one cycle)
//   o_period_start   high on the first cycle (count 0) of every RUN period
//   o_applied        one-cycle pulse after pending shadow values go active
//   o_count          current period counter

module pwm_generator #(
    parameter int unsigned TOP_W = 8,
    parameter int unsigned CMP_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [TOP_W-1:0] i_top,
    input  logic             i_top_valid,
    input  logic [CMP_W-1:0] i_compare,
    input  logic             i_compare_valid,
    output logic             o_pwm,
    output logic             o_period_start,
    output logic             o_applied,
    output logic [TOP_W-1:0] o_count
);

    typedef enum logic {
        S_DISABLED = 1'b0,
        S_RUN      = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [TOP_W-1:0] count_q, count_d;
    logic [TOP_W-1:0] top_q, top_d;
    logic [CMP_W-1:0] cmp_q, cmp_d;
    logic [TOP_W-1:0] sh_top_q, sh_top_d;
    logic [CMP_W-1:0] sh_cmp_q, sh_cmp_d;
    logic             p_top_q, p_top_d;
    logic             p_cmp_q, p_cmp_d;
    logic             pwm_q, pwm_d;
    logic             applied_q, applied_d;

    logic boundary;
    logic apply_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_DISABLED;
            count_q   <= '0;
            top_q     <= '1;
            cmp_q     <= '0;
            sh_top_q  <= '0;
            sh_cmp_q  <= '0;
            p_top_q   <= 1'b0;
            p_cmp_q   <= 1'b0;
            pwm_q     <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            top_q     <= top_d;
            cmp_q     <= cmp_d;
            sh_top_q  <= sh_top_d;
            sh_cmp_q  <= sh_cmp_d;
            p_top_q   <= p_top_d;
            p_cmp_q   <= p_cmp_d;
            pwm_q     <= pwm_d;
            applied_q <= applied_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        top_d     = top_q;
        cmp_d     = cmp_q;
        sh_top_d  = sh_top_q;
        sh_cmp_d  = sh_cmp_q;
        p_top_d   = p_top_q;
        p_cmp_d   = p_cmp_q;
        pwm_d     = 1'b0;
        applied_d = 1'b0;

        boundary = (state_q == S_RUN) && (count_q == top_q);
        // Active registers may only change where the counter restarts at 0.
        apply_ok = boundary || (state_q == S_DISABLED);

        if (i_top_valid) begin
            sh_top_d = i_top;
        end
        if (i_compare_valid) begin
            sh_cmp_d = i_compare;
        end

        if (apply_ok) begin
            // Pending value first, then a same-cycle strobe overrides it
            // (bypass): the newest write always wins and no flag is left set.
            if (p_top_q) begin
                top_d = sh_top_q;
            end
            if (p_cmp_q) begin
                cmp_d = sh_cmp_q;
            end
            if (i_top_valid) begin
                top_d = i_top;
            end
            if (i_compare_valid) begin
                cmp_d = i_compare;
            end
            p_top_d   = 1'b0;
            p_cmp_d   = 1'b0;
            applied_d = p_top_q || p_cmp_q;
        end else begin
            if (i_top_valid) begin
                p_top_d = 1'b1;
            end
            if (i_compare_valid) begin
                p_cmp_d = 1'b1;
            end
        end

        case (state_q)
            S_DISABLED: begin
                count_d = '0;
                if (i_enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_enable) begin
                    state_d = S_DISABLED;
                    count_d = '0;
                end else begin
                    count_d = boundary ? '0 : count_q + TOP_W'(1);
                    pwm_d   = CMP_W'(count_q) < cmp_q;
                end
            end
            default: begin
                state_d = S_DISABLED;
                count_d = '0;
            end
        endcase
    end

    assign o_pwm          = pwm_q;
    assign o_applied      = applied_q;
    assign o_count        = count_q;
    assign o_period_start = (state_q == S_RUN) && (count_q == '0);

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator
//   Directed-vector bench for pwm_generator (TOP_W = 8, CMP_W = 9).
//   Inputs change 1 ns after the rising edge and outputs are read at the
//   same point, so each tick() shows the register state after one edge.

module tb_pwm_generator;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_enable;
    logic [7:0] i_top;
    logic       i_top_valid;
    logic [8:0] i_compare;
    logic       i_compare_valid;
    logic       o_pwm;
    logic       o_period_start;
    logic       o_applied;
    logic [7:0] o_count;

    int n_vec;
    int n_err;

    pwm_generator #(
        .TOP_W(8),
        .CMP_W(9)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_top          (i_top),
        .i_top_valid    (i_top_valid),
        .i_compare      (i_compare),
        .i_compare_valid(i_compare_valid),
        .o_pwm          (o_pwm),
        .o_period_start (o_period_start),
        .o_applied      (o_applied),
        .o_count        (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Run n cycles; optionally strobe a compare value before edge s1_at / s2_at
    // (index 0 = the edge that sees the current count). Tallies outputs.
    task automatic measure(input int n,
                           input int s1_at, input logic [8:0] s1_v,
                           input int s2_at, input logic [8:0] s2_v,
                           output int highs, output int starts, output int appl);
        highs  = 0;
        starts = 0;
        appl   = 0;
        for (int i = 0; i < n; i++) begin
            i_compare_valid = 1'b0;
            if (i == s1_at) begin
                i_compare_valid = 1'b1;
                i_compare       = s1_v;
            end else if (i == s2_at) begin
                i_compare_valid = 1'b1;
                i_compare       = s2_v;
            end
            tick();
            i_compare_valid = 1'b0;
            highs  += int'(o_pwm);
            starts += int'(o_period_start);
            appl   += int'(o_applied);
        end
    endtask

    int h, s, a;

    initial begin
        n_vec           = 0;
        n_err           = 0;
        i_rst_n         = 1'b0;
        i_enable        = 1'b0;
        i_top           = '0;
        i_top_valid     = 1'b0;
        i_compare       = '0;
        i_compare_valid = 1'b0;
        repeat (3) tick();

        // Reset defaults
        check_eq("rst_pwm", int'(o_pwm), 0);
        check_eq("rst_start", int'(o_period_start), 0);
        check_eq("rst_applied", int'(o_applied), 0);
        check_eq("rst_count", int'(o_count), 0);

        // Run on defaults, then assert reset asynchronously mid-period
        i_rst_n  = 1'b1;
        i_enable = 1'b1;
        tick();
        check_eq("en_count0", int'(o_count), 0);
        check_eq("en_start", int'(o_period_start), 1);
        repeat (50) tick();
        check_eq("run_count50", int'(o_count), 50);
        i_rst_n = 1'b0;
        #1;
        check_eq("async_rst_count", int'(o_count), 0);
        check_eq("async_rst_start", int'(o_period_start), 0);
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        check_eq("rerun_start", int'(o_period_start), 1);
        measure(256, -1, '0, -1, '0, h, s, a);
        check_eq("dflt_highs", h, 0);
        check_eq("dflt_starts", s, 1);
        check_eq("dflt_wrap", int'(o_count), 0);

        // Basic duty: program while disabled (bypass, no o_applied)
        i_enable    = 1'b0;
        tick();
        i_top       = 8'd9;
        i_top_valid = 1'b1;
        tick();
        i_top_valid = 1'b0;
        check_eq("dis_bypass_top_appl", int'(o_applied), 0);
        measure(1, 0, 9'd3, -1, '0, h, s, a);
        check_eq("dis_bypass_cmp_appl", a, 0);
        i_enable = 1'b1;
        tick();
        check_eq("basic_start", int'(o_period_start), 1);
        measure(10, -1, '0, -1, '0, h, s, a);
        check_eq("basic_highs1", h, 3);
        check_eq("basic_starts1", s, 1);
        measure(10, -1, '0, -1, '0, h, s, a);
        check_eq("basic_highs2", h, 3);
        check_eq("basic_count", int'(o_count), 0);

        // Deferred update at count 4
        measure(10, 4, 9'd7, -1, '0, h, s, a);
        check_eq("defer_cur_highs", h, 3);
        check_eq("defer_applied", a, 1);
        measure(10, -1, '0, -1, '0, h, s, a);
        check_eq("defer_next_highs", h, 7);
        check_eq("defer_next_appl", a, 0);

        // Boundary bypass at count 9
        measure(10, 9, 9'd5, -1, '0, h, s, a);
        check_eq("bypass_cur_highs", h, 7);
        check_eq("bypass_applied", a, 0);
        measure(10, -1, '0, -1, '0, h, s, a);
        check_eq("bypass_next_highs", h, 5);

        // Last write wins
        measure(10, 2, 9'd2, 6, 9'd8, h, s, a);
        check_eq("lww_cur_highs", h, 5);
        check_eq("lww_applied", a, 1);
        measure(10, -1, '0, -1, '0, h, s, a);
        check_eq("lww_next_highs", h, 8);
        check_eq("lww_starts", s, 1);

        // Disable mid-period with pending top=0, compare=1
        tick();
        tick();
        i_top           = 8'd0;
        i_top_valid     = 1'b1;
        i_compare       = 9'd1;
        i_compare_valid = 1'b1;
        tick();
        i_top_valid     = 1'b0;
        i_compare_valid = 1'b0;
        tick();
        tick();
        check_eq("pre_dis_count", int'(o_count), 5);
        check_eq("pre_dis_pwm", int'(o_pwm), 1);
        i_enable = 1'b0;
        tick();
        check_eq("dis_pwm", int'(o_pwm), 0);
        check_eq("dis_count", int'(o_count), 0);
        check_eq("dis_start", int'(o_period_start), 0);
        tick();
        check_eq("dis_applied", int'(o_applied), 1);
        tick();
        check_eq("dis_applied_clr", int'(o_applied), 0);
        i_enable = 1'b1;
        tick();
        check_eq("reen_count", int'(o_count), 0);
        check_eq("reen_start", int'(o_period_start), 1);

        // top = 0, compare = 1
        measure(8, -1, '0, -1, '0, h, s, a);
        check_eq("top0_highs", h, 8);
        check_eq("top0_starts", s, 8);

        // top = 255, compare = 256
        i_enable = 1'b0;
        tick();
        i_top           = 8'd255;
        i_top_valid     = 1'b1;
        i_compare       = 9'd256;
        i_compare_valid = 1'b1;
        tick();
        i_top_valid     = 1'b0;
        i_compare_valid = 1'b0;
        check_eq("full_set_appl", int'(o_applied), 0);
        i_enable = 1'b1;
        tick();
        measure(256, 10, 9'd0, -1, '0, h, s, a);
        check_eq("full_highs", h, 256);
        check_eq("full_starts", s, 1);
        check_eq("zero_pend_appl", a, 1);
        measure(256, -1, '0, -1, '0, h, s, a);
        check_eq("zero_highs", h, 0);
        check_eq("zero_starts", s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
